// File: rtl/dcache_pkg.sv
// dcache_pkg: cache geometry, controller state type and address field helpers
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;
  localparam int TAG_W  = 22;
  localparam int IDX_W  = 5;
  localparam int WORD_W = 3;
  localparam int LINE_W = 256;
  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:10];
  endfunction
  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return a[9:5];
  endfunction
  function automatic logic [WORD_W-1:0] addr_word(input logic [31:0] a);
    return a[4:2];
  endfunction
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i);
    return {t, i, 5'b0};
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage with async read, word and line write ports
module dcache_array import dcache_pkg::*; #(
  parameter int LINES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_data_o,
  input  logic              ww_en_i,
  input  logic [IDX_W-1:0]  ww_idx_i,
  input  logic [WORD_W-1:0] ww_word_i,
  input  logic [31:0]       ww_data_i,
  input  logic              lw_en_i,
  input  logic [IDX_W-1:0]  lw_idx_i,
  input  logic [TAG_W-1:0]  lw_tag_i,
  input  logic [LINE_W-1:0] lw_data_i
);
  logic [LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];
  // store hit marks the line dirty; refill installs it valid and clean
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (ww_en_i) dirty_d[ww_idx_i] = 1'b1;
    if (lw_en_i) begin
      valid_d[lw_idx_i] = 1'b1;
      dirty_d[lw_idx_i] = 1'b0;
    end
  end
  // line state flops, cleared by reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end
  // tag and data storage, untouched while reset is asserted
  always_ff @(posedge clk_i) begin
    if (rst_i && ww_en_i) data_q[ww_idx_i][{ww_word_i, 5'b0} +: 32] <= ww_data_i;
    if (rst_i && lw_en_i) begin
      data_q[lw_idx_i] <= lw_data_i;
      tag_q[lw_idx_i]  <= lw_tag_i;
    end
  end
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate data cache with line refill FSM
module dcache_controller import dcache_pkg::*; #(
  parameter int LINES      = 32,
  parameter int LINE_BYTES = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cpu_req_i,
  input  logic                    cpu_we_i,
  input  logic [ADDR_W-1:0]       cpu_addr_i,
  input  logic [31:0]             cpu_wdata_i,
  output logic [31:0]             cpu_rdata_o,
  output logic                    cpu_stall_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [LINE_BYTES*8-1:0] mem_wdata_o,
  input  logic [LINE_BYTES*8-1:0] mem_rdata_i,
  input  logic                    mem_ack_i
);
  state_e state_q, state_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, fill_addr_q, fill_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic rd_valid, rd_dirty, hit, idle, victim_dirty;
  logic [TAG_W-1:0] rd_tag, tag;
  logic [IDX_W-1:0] idx;
  logic [WORD_W-1:0] word;
  logic [LINE_W-1:0] rd_data;
  assign tag          = addr_tag(cpu_addr_i);
  assign idx          = addr_idx(cpu_addr_i);
  assign word         = addr_word(cpu_addr_i);
  assign idle         = state_q == IDLE;
  assign hit          = cpu_req_i & rd_valid & (rd_tag == tag);
  assign victim_dirty = rd_valid & rd_dirty;
  assign cpu_stall_o  = cpu_req_i & (!idle | !hit);
  assign cpu_rdata_o  = (idle & hit & !cpu_we_i) ? rd_data[{word, 5'b0} +: 32] : '0;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  dcache_array #(.LINES(LINES)) u_array (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .ww_en_i    (idle & hit & cpu_we_i),
    .ww_idx_i   (idx),
    .ww_word_i  (word),
    .ww_data_i  (cpu_wdata_i),
    .lw_en_i    ((state_q == ALLOCATE) & mem_ack_i),
    .lw_idx_i   (addr_idx(mem_addr_q)),
    .lw_tag_i   (addr_tag(mem_addr_q)),
    .lw_data_i  (mem_rdata_i)
  );
  // next state and next registered memory-interface outputs
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill_addr_d = fill_addr_q;
    case (state_q)
      IDLE: if (cpu_req_i && !hit) begin
        fill_addr_d = line_addr(tag, idx);
        state_d     = victim_dirty ? WRITEBACK : ALLOCATE;
        mem_req_d   = 1'b1;
        mem_we_d    = victim_dirty;
        mem_addr_d  = victim_dirty ? line_addr(rd_tag, idx) : line_addr(tag, idx);
        mem_wdata_d = victim_dirty ? rd_data : '0;
      end
      WRITEBACK: if (mem_ack_i) begin
        state_d     = ALLOCATE;
        mem_we_d    = 1'b0;
        mem_addr_d  = fill_addr_q;
        mem_wdata_d = '0;
      end
      ALLOCATE: if (mem_ack_i) begin
        state_d    = IDLE;
        mem_req_d  = 1'b0;
        mem_addr_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // FSM and memory-interface registers; reset abandons any transfer
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fill_addr_q <= fill_addr_d;
    end
  end
endmodule
